bip_control: RTL and testbench

Control unit for the BIP accumulator processor: fetches 16-bit instructions from program memory, decodes the 5-bit opcode, and drives the datapath control lines `SelA`, `SelB`, `WrAcc`, `Op` and the 11-bit operand. It also drives the data-memory read/write strobes. The block is the instruction-side counterpart of `datapath`, and together they form the CPU core. It owns the program counter and a small fetch/execute/halt state machine.

---
 rtl/bip_pkg.sv | 21 ++
 rtl/bip_pc.sv | 22 ++
 rtl/bip_control.sv | 109 ++++++++++
 tb/tb_bip_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
// bip_pkg: shared widths, opcodes, FSM states and SelA encodings for the BIP control unit.
package bip_pkg;
    localparam int NBITS_O = 11;
    localparam int NBITS_E = 5;
    localparam int NBITS_D = 16;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
endpackage

// File: rtl/bip_pc.sv
// bip_pc: program counter with increment, clear and hold; wraps silently at the top.
module bip_pc
    import bip_pkg::*;
#(
    parameter int W = NBITS_O
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] pc_o
);
    logic [W-1:0] pc_q, pc_d;

    always_comb pc_d = clr_i ? '0 : inc_i ? pc_q + 1'b1 : pc_q;

    always_ff @(posedge i_clock or negedge i_reset)
        if (!i_reset) pc_q <= '0;
        else          pc_q <= pc_d;

    assign pc_o = pc_q;
endmodule

// File: rtl/bip_control.sv
// bip_control: BIP fetch/exec/halt control unit driving datapath and data-memory strobes.
// Optional BIP_CYCLE_CNT_EN adds a 32-bit o_cycles count of FETCH/EXEC cycles.
module bip_control
    import bip_pkg::*;
#(
    parameter int NBITS_O = bip_pkg::NBITS_O,
    parameter int NBITS_E = bip_pkg::NBITS_E,
    parameter int NBITS_D = bip_pkg::NBITS_D
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_Instruction,
    output logic [NBITS_O-1:0] o_Addr_prog,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_WrAcc,
    output logic               o_Op,
    output logic [NBITS_O-1:0] o_Operand,
    output logic               o_WrRAM,
    output logic               o_RdRAM,
    output logic               o_halt
`ifdef BIP_CYCLE_CNT_EN
    ,output logic [31:0]       o_cycles
`endif
);
    state_t state_q, state_d;
    logic pc_inc, pc_clr;
    logic [NBITS_E-1:0] opcode;

    assign opcode = i_Instruction[NBITS_D-1 -: NBITS_E];

    always_ff @(posedge i_clock or negedge i_reset)
        if (!i_reset) state_q <= IDLE;
        else          state_q <= state_d;

    // Strobes are only ever driven in EXEC, so an async reset drops them at once.
    always_comb begin
        state_d   = state_q;
        pc_inc    = 1'b0;
        pc_clr    = 1'b0;
        o_SelA    = SELA_RAM;
        o_SelB    = 1'b0;
        o_WrAcc   = 1'b0;
        o_Op      = 1'b0;
        o_Operand = '0;
        o_WrRAM   = 1'b0;
        o_RdRAM   = 1'b0;
        case (state_q)
            IDLE:  if (i_start) state_d = FETCH;
            FETCH: state_d = EXEC;
            EXEC: begin
                o_Operand = i_Instruction[NBITS_O-1:0];
                state_d   = (opcode == OP_HLT) ? HALT : FETCH;
                pc_inc    = (opcode != OP_HLT);
                case (opcode)
                    OP_STO: o_WrRAM = 1'b1;
                    OP_LD: begin
                        o_RdRAM = 1'b1;
                        o_WrAcc = 1'b1;
                    end
                    OP_LDI: begin
                        o_SelA  = SELA_IMM;
                        o_WrAcc = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        o_RdRAM = 1'b1;
                        o_SelA  = SELA_ALU;
                        o_Op    = (opcode == OP_SUB);
                        o_WrAcc = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        o_SelA  = SELA_ALU;
                        o_SelB  = 1'b1;
                        o_Op    = (opcode == OP_SUBI);
                        o_WrAcc = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT: begin
                pc_clr  = i_start;
                state_d = i_start ? FETCH : HALT;
            end
        endcase
    end

    assign o_halt = (state_q == HALT);

    bip_pc #(.W(NBITS_O)) u_pc (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .inc_i  (pc_inc),
        .clr_i  (pc_clr),
        .pc_o   (o_Addr_prog)
    );

`ifdef BIP_CYCLE_CNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb cyc_d = pc_clr ? '0 : (state_q == FETCH || state_q == EXEC) ? cyc_q + 1'b1 : cyc_q;

    always_ff @(posedge i_clock or negedge i_reset)
        if (!i_reset) cyc_q <= '0;
        else          cyc_q <= cyc_d;

    assign o_cycles = cyc_q;
`endif
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: directed-vector bench for bip_control against a registered program memory.
module tb_bip_control;
    import bip_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = '0;
    logic [10:0] addr, operand;
    logic [1:0]  sela;
    logic        selb, wracc, op, wrram, rdram, halt;
    logic [6:0]  ctrl;
    logic [15:0] mem [2048];
    int n_chk = 0;
    int n_fail = 0;
`ifdef BIP_CYCLE_CNT_EN
    logic [31:0] cycles;
`endif

    bip_control dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_start      (start),
        .i_Instruction(instr),
        .o_Addr_prog  (addr),
        .o_SelA       (sela),
        .o_SelB       (selb),
        .o_WrAcc      (wracc),
        .o_Op         (op),
        .o_Operand    (operand),
        .o_WrRAM      (wrram),
        .o_RdRAM      (rdram),
        .o_halt       (halt)
`ifdef BIP_CYCLE_CNT_EN
        ,.o_cycles    (cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) instr <= mem[addr];

    // {SelA, SelB, WrAcc, Op, WrRAM, RdRAM}
    assign ctrl = {sela, selb, wracc, op, wrram, rdram};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
        mem[0] = {OP_LDI, 11'd123};
        mem[1] = {OP_ADDI, 11'd5};
        mem[2] = {OP_SUBI, 11'd3};
        mem[3] = {OP_HLT, 11'd0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ctrl", ctrl, 7'b0);
            check("idle_addr", addr, 0);
            check("idle_halt", halt, 0);
        end
`ifdef BIP_CYCLE_CNT_EN
        check("idle_cycles", cycles, 0);
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("f0_addr", addr, 0);
        check("f0_ctrl", ctrl, 7'b0);
        @(negedge clk);
        check("ldi_ctrl", ctrl, 7'b01_0_1_0_0_0);
        check("ldi_operand", operand, 123);
        @(negedge clk);
        check("f1_addr", addr, 1);
        check("f1_ctrl", ctrl, 7'b0);
        check("f1_operand", operand, 0);
        @(negedge clk);
        check("addi_ctrl", ctrl, 7'b10_1_1_0_0_0);
        check("addi_operand", operand, 5);
        @(negedge clk);
        check("f2_addr", addr, 2);
        @(negedge clk);
        check("subi_ctrl", ctrl, 7'b10_1_1_1_0_0);
        check("subi_operand", operand, 3);
        @(negedge clk);
        check("f3_addr", addr, 3);
        @(negedge clk);
        check("hlt_ctrl", ctrl, 7'b0);
        check("hlt_exec_halt", halt, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt", halt, 1);
            check("halt_addr", addr, 3);
            check("halt_ctrl", ctrl, 7'b0);
        end
`ifdef BIP_CYCLE_CNT_EN
        check("halt_cycles", cycles, 8);
`endif
        mem[0] = {OP_STO, 11'd7};
        mem[1] = {OP_LD, 11'd7};
        mem[2] = 16'hF805;
        mem[3] = {OP_ADD, 11'd9};
        mem[4] = {OP_HLT, 11'd0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rs_addr", addr, 0);
        check("rs_halt", halt, 0);
`ifdef BIP_CYCLE_CNT_EN
        check("rs_cycles", cycles, 0);
`endif
        @(negedge clk);
        check("sto_ctrl", ctrl, 7'b00_0_0_0_1_0);
        check("sto_operand", operand, 7);
        @(negedge clk);
        check("sto_width", ctrl, 7'b0);
        check("f1b_addr", addr, 1);
        @(negedge clk);
        check("ld_ctrl", ctrl, 7'b00_0_1_0_0_1);
        check("ld_operand", operand, 7);
        @(negedge clk);
        check("f2b_addr", addr, 2);
        @(negedge clk);
        check("nop_ctrl", ctrl, 7'b0);
        @(negedge clk);
        check("nop_pc_adv", addr, 3);
        @(negedge clk);
        check("add_ctrl", ctrl, 7'b10_0_1_0_0_1);
        check("add_operand", operand, 9);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ctrl", ctrl, 7'b0);
        check("rst_operand", operand, 0);
        check("rst_addr", addr, 0);
        check("rst_halt", halt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_ctrl", ctrl, 7'b0);
            check("post_rst_addr", addr, 0);
        end
`ifdef BIP_CYCLE_CNT_EN
        check("post_rst_cycles", cycles, 0);
`endif
        for (int i = 0; i < 5; i++) mem[i] = 16'hF800;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * 2047) @(negedge clk);
        check("wrap_top", addr, 2047);
        @(negedge clk);
        check("wrap_nop_ctrl", ctrl, 7'b0);
        @(negedge clk);
        check("wrap_zero", addr, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
